// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder: S1 registers operands, S2 holds
// group carries; sum/cout/ovf ripple inside each group from S2 state.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, a, b, cin;
//   out_valid/out_ready, sum, cout, ovf, grp_p, grp_g (NG = WIDTH/GROUP).
// Option: CLA_ADDER_PIPE_SUB_EN adds input sub (sum = a - b when set).
// WIDTH must be a multiple of GROUP and at least GROUP.
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   cin,
`ifdef CLA_ADDER_PIPE_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       sum,
    output logic                   cout,
    output logic                   ovf,
    output logic [WIDTH/GROUP-1:0] grp_p,
    output logic [WIDTH/GROUP-1:0] grp_g
);

    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

`ifdef CLA_ADDER_PIPE_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub | cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a <= a;
                s1_b <= b_eff;
                s1_c <= c_eff;
            end
        end
    end

    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] bg;
    logic [WIDTH-1:0] bx;

    assign bp = s1_a | s1_b;
    assign bg = s1_a & s1_b;
    assign bx = s1_a ^ s1_b;

    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG-1:0] cgrp;

    // Group lookahead: cgrp[j] is the carry entering group j.
    always_comb begin
        logic acc;
        logic c;
        gp   = '0;
        gg   = '0;
        cgrp = '0;
        acc  = 1'b0;
        c    = s1_c;
        for (int j = 0; j < NG; j++) begin
            acc = 1'b0;
            for (int k = 0; k < GROUP; k++) begin
                acc = bg[j*GROUP+k] | (bp[j*GROUP+k] & acc);
            end
            gp[j]   = &bp[j*GROUP +: GROUP];
            gg[j]   = acc;
            cgrp[j] = c;
            c       = acc | (gp[j] & c);
        end
    end

    logic [WIDTH-1:0] s2_x;
    logic [WIDTH-1:0] s2_p;
    logic [WIDTH-1:0] s2_g;
    logic [NG-1:0]    s2_c;
    logic [NG-1:0]    s2_gp;
    logic [NG-1:0]    s2_gg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s2_x      <= '0;
            s2_p      <= '0;
            s2_g      <= '0;
            s2_c      <= '0;
            s2_gp     <= '0;
            s2_gg     <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s2_x  <= bx;
                s2_p  <= bp;
                s2_g  <= bg;
                s2_c  <= cgrp;
                s2_gp <= gp;
                s2_gg <= gg;
            end
        end
    end

    // In-group ripple from the held S2 state; outputs stay stable
    // whenever S2 does not advance.
    always_comb begin
        logic c;
        logic c_msb;
        sum   = '0;
        c     = 1'b0;
        c_msb = 1'b0;
        for (int j = 0; j < NG; j++) begin
            c = s2_c[j];
            for (int k = 0; k < GROUP; k++) begin
                sum[j*GROUP+k] = s2_x[j*GROUP+k] ^ c;
                c_msb          = c;
                c = s2_g[j*GROUP+k] | (s2_p[j*GROUP+k] & c);
            end
        end
        cout = c;
        ovf  = c_msb ^ c;
    end

    assign grp_p = s2_gp;
    assign grp_g = s2_gg;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Testbench for cla_adder_pipe (WIDTH=16, GROUP=4): directed vectors,
// bubbles, backpressure, mid-run reset and random traffic vs a model.
module tb_cla_adder_pipe;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NG = W / G;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [NG-1:0] grp_p;
    logic [NG-1:0] grp_g;

    cla_adder_pipe #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_ADDER_PIPE_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .grp_p     (grp_p),
        .grp_g     (grp_g)
    );

    always #5 clk = ~clk;

    typedef logic [W+2+2*NG-1:0] res_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_push  = 0;
    int   n_pop   = 0;
    res_t sbq[$];
    res_t held;
    res_t mon_e;
    logic stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, group flags from nibble sums.
    function automatic res_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        logic [W-1:0]  yy;
        logic [W:0]    full;
        logic [W-1:0]  s;
        logic          o;
        logic [NG-1:0] gp;
        logic [NG-1:0] gg;
        logic [G:0]    ns;
        logic [W-1:0]  orv;
        yy   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + (W+1)'(sb | ci);
        s    = full[W-1:0];
        o    = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
        orv  = x | yy;
        for (int j = 0; j < NG; j++) begin
            gp[j] = (orv[j*G +: G] == {G{1'b1}});
            ns    = {1'b0, x[j*G +: G]} + {1'b0, yy[j*G +: G]};
            gg[j] = ns[G];
        end
        return {s, full[W], o, gp, gg};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_push = n_push - sbq.size();
            sbq.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {sum, cout, ovf, grp_p, grp_g}, held);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("extra_out", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    n_pop++;
                    check("out_data", {sum, cout, ovf, grp_p, grp_g},
                          mon_e);
                end
            end
            stall = out_valid && !out_ready;
            held  = {sum, cout, ovf, grp_p, grp_g};
            if (in_valid && in_ready) begin
                sbq.push_back(model(a, b, cin, sub));
                n_push++;
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb);
        logic ok;
        ok       = 1'b0;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = sb;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_ok", {31'd0, ok}, 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic ci,
                           input logic sb, input res_t e);
        send(x, y, ci, sb);
        @(negedge clk);
        check({tag, "_lat"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, {sum, cout, ovf, grp_p, grp_g}, e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_res"}, {sum, cout, ovf, grp_p, grp_g}, 32'd0);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            cin       = 1'($urandom_range(0, 1));
`ifdef CLA_ADDER_PIPE_SUB_EN
            sub       = 1'($urandom_range(0, 1));
`endif
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    logic [W-1:0] bp_a[4] = '{16'h0001, 16'hABCD, 16'hFFFF, 16'h7000};
    logic [W-1:0] bp_b[4] = '{16'h0002, 16'h1111, 16'h0001, 16'h1000};
    logic [5:0]   pat;
    int           acc;
    int           idx;
    int           pop0;
    logic         ok;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        run_vec("ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0,
                {16'h0000, 1'b1, 1'b0, 4'b1111, 4'b0001});
        run_vec("1234", 16'h1234, 16'h4321, 1'b1, 1'b0,
                {16'h5556, 1'b0, 1'b0, 4'b0000, 4'b0000});
        run_vec("7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
                {16'h8000, 1'b0, 1'b1, 4'b0111, 4'b0001});
        run_vec("wrap", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0,
                {16'hFFFF, 1'b1, 1'b0, 4'b1111, 4'b1111});
`ifdef CLA_ADDER_PIPE_SUB_EN
        run_vec("sub5_7", 16'h0005, 16'h0007, 1'b0, 1'b1,
                {16'hFFFE, 1'b0, 1'b0, 4'b1110, 4'b0000});
        run_vec("sub8000", 16'h8000, 16'h0001, 1'b0, 1'b1,
                {16'h7FFF, 1'b1, 1'b1, 4'b1110, 4'b1000});
        sub = 1'b0;
`endif

        // Bubbles: in_valid 1,0,1 -> out_valid 1,0,1 two cycles later.
        for (int i = 0; i < 6; i++) begin
            in_valid = (i == 0 || i == 2);
            a        = pick();
            b        = pick();
            cin      = 1'($urandom_range(0, 1));
            @(negedge clk);
            pat[i] = out_valid;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bubble_pat", {26'd0, pat}, 32'b010100);

        // Backpressure: out_ready low for 3 cycles while streaming.
        pop0      = n_pop;
        out_ready = 1'b0;
        acc       = 0;
        idx       = 0;
        a         = bp_a[0];
        b         = bp_b[0];
        cin       = 1'b0;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) acc++;
            @(posedge clk);
            #1;
            if (ok) begin
                idx++;
                a = bp_a[idx];
                b = bp_b[idx];
            end
        end
        check("bp_accepts", acc, 32'd2);
        @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = idx; i < 4; i++) begin
            send(bp_a[i], bp_b[i], 1'b0, 1'b0);
        end
        repeat (4) @(posedge clk);
        #1;
        check("bp_pops", n_pop - pop0, 32'd4);

        rand_cycles(400);

        // Reset with beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h1111;
        b         = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("rst2");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rst2_no_out", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        rand_cycles(150);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain_q", sbq.size(), 32'd0);
        check("push_pop", n_pop, n_push);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
